// File: rtl/fp_normalize_round_pkg.sv
// Shared widths, constants and FSM state encoding
// for the FP normalize/round back end.
package fp_normalize_round_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int               BIAS    = 127;

  localparam int HID_BIT = 26;
  localparam int G_BIT   = 2;
  localparam int R_BIT   = 1;
  localparam int S_BIT   = 0;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CHECK = 4'd1,
    CARRY = 4'd2,
    SHIFT = 4'd3,
    ROUND = 4'd4,
    PACK  = 4'd5,
    ZERO  = 4'd6,
    UFLOW = 4'd7,
    OFLOW = 4'd8
  } state_e;

  function automatic logic rne_up(
    input logic [MANT_W-1:0] m
  );
    return m[G_BIT] & (m[R_BIT] | m[S_BIT] | m[3]);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on the 24-bit significand;
// round_ovf_o flags a carry out of the hidden bit.
module fp_round_rne
  import fp_normalize_round_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  output logic [FRAC_W:0]   mant_r_o,
  output logic              round_ovf_o
);

  logic up;

  // increment the kept bits when GRS rounds up
  always_comb begin
    up = rne_up(mant_i);
    {round_ovf_o, mant_r_o} =
      {1'b0, mant_i[MANT_W-1:3]} + {{FRAC_W+1{1'b0}}, up};
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Normalize, round and pack an IEEE-754 single
// from the raw mantissa ALU result.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              carry_in,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  state_e            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              carry_q, carry_d;
  logic              sign_q, sign_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              done_q, done_d;

  logic [FRAC_W:0]   mant_r;
  logic              round_ovf;
  logic [EXP_W:0]    exp_rnd;

  fp_round_rne u_rne (
    .mant_i      (mant_q),
    .mant_r_o    (mant_r),
    .round_ovf_o (round_ovf)
  );

  // state, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      done_q   <= done_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    done_d   = 1'b0;
    exp_rnd  = exp_q + {{EXP_W{1'b0}}, round_ovf};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mant_d  = mant_in;
          carry_d = carry_in;
          sign_d  = sign_in;
          exp_d   = {1'b0, exp_in};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (exp_q == {1'b0, EXP_MAX})
          state_d = OFLOW;
        else if (carry_q)
          state_d = CARRY;
        else if (mant_q == '0)
          state_d = ZERO;
        else if (exp_q == '0)
          state_d = UFLOW;
        else if (mant_q[HID_BIT])
          state_d = ROUND;
        else
          state_d = SHIFT;
      end
      CARRY: begin
        mant_d  = {1'b1, mant_q[MANT_W-1:2],
                   mant_q[R_BIT] | mant_q[S_BIT]};
        exp_d   = exp_q + 1'b1;
        carry_d = 1'b0;
        state_d = ROUND;
      end
      // shift and look ahead at the new hidden bit
      SHIFT: begin
        if (exp_q == 9'd1) begin
          state_d = UFLOW;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 1'b1;
          if (mant_q[HID_BIT-1])
            state_d = ROUND;
        end
      end
      ROUND: begin
        if (round_ovf)
          mant_d[MANT_W-1:3] = 24'h800000;
        else
          mant_d[MANT_W-1:3] = mant_r;
        exp_d = exp_rnd;
        if (exp_rnd >= {1'b0, EXP_MAX})
          state_d = OFLOW;
        else
          state_d = PACK;
      end
      PACK: begin
        result_d = {sign_q, exp_q[EXP_W-1:0],
                    mant_q[FRAC_W+2:3]};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      ZERO: begin
        result_d = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      UFLOW: begin
        result_d = {sign_q, 31'h0};
        ovf_d    = 1'b0;
        unf_d    = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      OFLOW: begin
        result_d = {sign_q, EXP_MAX, 23'h0};
        ovf_d    = 1'b1;
        unf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed self-checking bench for
// fp_normalize_round.
module tb_fp_normalize_round;

  localparam int LIM = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] mant_in = '0;
  logic        carry_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        busy, done, overflow, underflow;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp_normalize_round dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mant_in   (mant_in),
    .carry_in  (carry_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic launch(
    input  logic [26:0] m,
    input  logic        c,
    input  logic        s,
    input  logic [7:0]  e,
    output int          lat
  );
    @(negedge clk);
    mant_in  = m;
    carry_in = c;
    sign_in  = s;
    exp_in   = e;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < LIM) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, overflow, underflow} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl got %b want 0000",
               {busy, done, overflow, underflow});
    end
    tests++;
    if (result !== 32'h0) begin
      fails++;
      $display("FAIL reset_result got %h want 0", result);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal;
    int lat;
    launch(27'h4000000, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F800000 || lat !== 4) begin
      fails++;
      $display("FAIL one got %h lat %0d want 3f800000 lat 4",
               result, lat);
    end
    tests++;
    if ({overflow, underflow} !== 2'b00) begin
      fails++;
      $display("FAIL one_flags got %b want 00",
               {overflow, underflow});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse got done %b busy %b want 0 0",
               done, busy);
    end
    launch(27'h5800000, 1'b0, 1'b0, 8'd130, lat);
    tests++;
    if (result !== 32'h41300000) begin
      fails++;
      $display("FAIL eleven got %h want 41300000", result);
    end
  endtask

  task automatic test_carry;
    int lat;
    launch(27'h0, 1'b1, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h40000000 || lat !== 5) begin
      fails++;
      $display("FAIL carry got %h lat %0d want 40000000 lat 5",
               result, lat);
    end
    launch(27'h000000C, 1'b1, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h40000001) begin
      fails++;
      $display("FAIL carry_gr got %h want 40000001", result);
    end
    launch(27'h0000008, 1'b1, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h40000000) begin
      fails++;
      $display("FAIL carry_tie got %h want 40000000", result);
    end
    launch(27'h0000009, 1'b1, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h40000001) begin
      fails++;
      $display("FAIL carry_sticky got %h want 40000001", result);
    end
    launch(27'h0, 1'b1, 1'b0, 8'd254, lat);
    tests++;
    if (result !== 32'h7F800000 || overflow !== 1'b1
        || underflow !== 1'b0 || lat !== 5) begin
      fails++;
      $display("FAIL carry_ovf got %h o%b u%b lat %0d want 7f800000 o1 u0 lat 5",
               result, overflow, underflow, lat);
    end
  endtask

  task automatic test_shift;
    int lat;
    launch(27'h0000008, 1'b0, 1'b1, 8'd127, lat);
    tests++;
    if (result !== 32'hB4000000 || lat !== 27) begin
      fails++;
      $display("FAIL shift23 got %h lat %0d want b4000000 lat 27",
               result, lat);
    end
    tests++;
    if ({overflow, underflow} !== 2'b00) begin
      fails++;
      $display("FAIL shift23_flags got %b want 00",
               {overflow, underflow});
    end
    launch(27'h2000000, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F000000 || lat !== 5) begin
      fails++;
      $display("FAIL shift1 got %h lat %0d want 3f000000 lat 5",
               result, lat);
    end
    launch(27'h0000008, 1'b0, 1'b1, 8'd3, lat);
    tests++;
    if (result !== 32'h80000000 || underflow !== 1'b1
        || overflow !== 1'b0) begin
      fails++;
      $display("FAIL uflow got %h o%b u%b want 80000000 o0 u1",
               result, overflow, underflow);
    end
    launch(27'h4000000, 1'b0, 1'b0, 8'd0, lat);
    tests++;
    if (result !== 32'h0 || underflow !== 1'b1) begin
      fails++;
      $display("FAIL exp0 got %h u%b want 0 u1",
               result, underflow);
    end
    launch(27'h4000000, 1'b0, 1'b0, 8'd255, lat);
    tests++;
    if (result !== 32'h7F800000 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL exp255 got %h o%b want 7f800000 o1",
               result, overflow);
    end
  endtask

  task automatic test_round;
    int lat;
    launch(27'h7FFFFFC, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h40000000 || lat !== 4) begin
      fails++;
      $display("FAIL rnd_ovf got %h lat %0d want 40000000 lat 4",
               result, lat);
    end
    launch(27'h4000004, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F800000) begin
      fails++;
      $display("FAIL tie_even got %h want 3f800000", result);
    end
    launch(27'h400000C, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F800002) begin
      fails++;
      $display("FAIL tie_odd got %h want 3f800002", result);
    end
    launch(27'h4000005, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F800001) begin
      fails++;
      $display("FAIL above_half got %h want 3f800001", result);
    end
    launch(27'h4000003, 1'b0, 1'b0, 8'd127, lat);
    tests++;
    if (result !== 32'h3F800000) begin
      fails++;
      $display("FAIL below_half got %h want 3f800000", result);
    end
    launch(27'h7FFFFFC, 1'b0, 1'b1, 8'd254, lat);
    tests++;
    if (result !== 32'hFF800000 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL rnd_inf got %h o%b want ff800000 o1",
               result, overflow);
    end
  endtask

  task automatic test_zero;
    int lat;
    launch(27'h0, 1'b0, 1'b1, 8'd100, lat);
    tests++;
    if (result !== 32'h0 || {overflow, underflow} !== 2'b00
        || lat >= LIM) begin
      fails++;
      $display("FAIL zero got %h o%b u%b lat %0d want 0 o0 u0",
               result, overflow, underflow, lat);
    end
  endtask

  task automatic test_hold;
    int lat;
    launch(27'h0, 1'b1, 1'b1, 8'd254, lat);
    repeat (5) @(negedge clk);
    tests++;
    if (result !== 32'hFF800000 || overflow !== 1'b1
        || done !== 1'b0) begin
      fails++;
      $display("FAIL hold got %h o%b d%b want ff800000 o1 d0",
               result, overflow, done);
    end
  endtask

  task automatic test_busy_start;
    int lat;
    int extra;
    @(negedge clk);
    mant_in  = 27'h0000008;
    carry_in = 1'b0;
    sign_in  = 1'b1;
    exp_in   = 8'd127;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    mant_in = 27'h4000000;
    sign_in = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < LIM) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (result !== 32'hB4000000 || lat !== 27) begin
      fails++;
      $display("FAIL busy_start got %h lat %0d want b4000000 lat 27",
               result, lat);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    tests++;
    if (extra !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignored got %0d dones busy %b want 0 0",
               extra, busy);
    end
  endtask

  task automatic test_abort;
    int seen;
    @(negedge clk);
    mant_in  = 27'h0000008;
    carry_in = 1'b0;
    sign_in  = 1'b1;
    exp_in   = 8'd127;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_state got b%b d%b %h want b0 d0 0",
               busy, done, result);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0 || result !== 32'h0) begin
      fails++;
      $display("FAIL abort_nodone got %0d dones %h want 0 0",
               seen, result);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_carry();
    test_shift();
    test_round();
    test_zero();
    test_hold();
    test_busy_start();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
